// File: rtl/cs_measure.sv
// Compressed-sensing measurement stage: buffers N signed samples, then streams
// M measurements y[m] = sum_n (+/-1) * x[n] with chips taken from a 2047-bit PRBS.
module cs_measure #(
    parameter  int N  = 64,
    parameter  int M  = 16,
    parameter  int DW = 12,
    localparam int OW = DW + $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2047:0] prbs,
    input  logic          prbs_valid,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [OW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last
);

    localparam int NW = $clog2(N);
    localparam int RW = (M > 1) ? $clog2(M) : 1;

    localparam logic [1:0] ST_WAIT    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_COMPUTE = 2'd2;
    localparam logic [1:0] ST_EMIT    = 2'd3;

    localparam logic [NW-1:0] N_LAST   = NW'(N - 1);
    localparam logic [RW-1:0] M_LAST   = RW'(M - 1);
    localparam logic [10:0]   PTR_LAST = 11'd2046;

    logic [1:0]           state_q,   state_d;
    logic [NW-1:0]        n_q,       n_d;
    logic [RW-1:0]        row_q,     row_d;
    logic [10:0]          ptr_q,     ptr_d;
    logic signed [OW-1:0] acc_q,     acc_d;
    logic signed [OW-1:0] m_data_q,  m_data_d;
    logic                 s_ready_q, s_ready_d;
    logic                 m_valid_q, m_valid_d;
    logic                 m_last_q,  m_last_d;

    logic [DW-1:0]        samp_q [N];

    logic                 wr_en_s;
    logic signed [OW-1:0] sample_ext_s;
    logic signed [OW-1:0] term_s;
    logic signed [OW-1:0] sum_s;

    // Negation happens after sign extension, so the most negative sample cannot wrap.
    always_comb begin
        wr_en_s      = (state_q == ST_LOAD) && s_valid && s_ready_q;
        sample_ext_s = {{(OW-DW){samp_q[n_q][DW-1]}}, samp_q[n_q]};
        term_s       = prbs[ptr_q] ? sample_ext_s : -sample_ext_s;
        sum_s        = acc_q + term_s;
    end

    // Next-state and output-register logic; n_q doubles as the term index while computing.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        row_d     = row_q;
        ptr_d     = ptr_q;
        acc_d     = acc_q;
        m_data_d  = m_data_q;
        s_ready_d = s_ready_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        case (state_q)
            ST_WAIT: begin
                if (prbs_valid) begin
                    state_d   = ST_LOAD;
                    s_ready_d = 1'b1;
                    n_d       = '0;
                end else begin
                    s_ready_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (wr_en_s) begin
                    if (n_q == N_LAST) begin
                        state_d   = ST_COMPUTE;
                        s_ready_d = 1'b0;
                        n_d       = '0;
                        row_d     = '0;
                        ptr_d     = 11'd0;
                        acc_d     = '0;
                    end else begin
                        n_d = n_q + 1'b1;
                    end
                end else begin
                    n_d = n_q;
                end
            end
            ST_COMPUTE: begin
                acc_d = sum_s;
                ptr_d = (ptr_q == PTR_LAST) ? 11'd0 : ptr_q + 11'd1;
                if (n_q == N_LAST) begin
                    state_d   = ST_EMIT;
                    n_d       = '0;
                    m_valid_d = 1'b1;
                    m_data_d  = sum_s;
                    m_last_d  = (row_q == M_LAST);
                end else begin
                    n_d = n_q + 1'b1;
                end
            end
            ST_EMIT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    if (row_q == M_LAST) begin
                        state_d   = ST_LOAD;
                        s_ready_d = 1'b1;
                        n_d       = '0;
                    end else begin
                        state_d = ST_COMPUTE;
                        row_d   = row_q + 1'b1;
                        acc_d   = '0;
                    end
                end else begin
                    m_valid_d = 1'b1;
                end
            end
            default: begin
                state_d   = ST_WAIT;
                s_ready_d = 1'b0;
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
            end
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_WAIT;
            n_q       <= '0;
            row_q     <= '0;
            ptr_q     <= 11'd0;
            acc_q     <= '0;
            m_data_q  <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            row_q     <= row_d;
            ptr_q     <= ptr_d;
            acc_q     <= acc_d;
            m_data_q  <= m_data_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
        end
    end

    // Sample buffer; contents need no reset because every frame rewrites all N entries.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            samp_q[n_q] <= s_data;
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign m_data  = m_data_q;

endmodule

// File: tb/tb_cs_measure.sv
// Directed/randomized bench for cs_measure with an arithmetic reference model.
module tb_cs_measure;

    localparam int N  = 64;
    localparam int M  = 16;
    localparam int DW = 12;
    localparam int OW = DW + $clog2(N) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [2047:0] prbs;
    logic          prbs_valid;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [OW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;

    int checks = 0;
    int errors = 0;
    int x_arr [N];
    int exp_y [M];

    cs_measure #(.N(N), .M(M), .DW(DW)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .prbs       (prbs),
        .prbs_valid (prbs_valid),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // y[m] = sum over n of (+x or -x) chosen by chip (m*N+n) mod 2047
    task automatic build_model();
        for (int m = 0; m < M; m++) begin
            int s;
            s = 0;
            for (int n = 0; n < N; n++) begin
                int idx;
                idx = (m * N + n) % 2047;
                s += prbs[idx] ? x_arr[n] : -x_arr[n];
            end
            exp_y[m] = s;
        end
    endtask

    task automatic randomize_prbs();
        for (int w = 0; w < 64; w++) prbs[w*32 +: 32] = $urandom;
    endtask

    task automatic randomize_x();
        for (int n = 0; n < N; n++) x_arr[n] = int'($urandom_range(0, 4095)) - 2048;
    endtask

    task automatic send_frame(input bit gaps);
        int i;
        int cyc;
        int overlap;
        bit took;
        i = 0;
        cyc = 0;
        overlap = 0;
        while (i < N && cyc < 4 * N + 20) begin
            s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_data  = DW'(x_arr[i]);
            took    = s_valid && s_ready;
            if (s_ready && m_valid) overlap++;
            step();
            cyc++;
            if (took) i++;
        end
        s_valid = 1'b0;
        chk("frame_loaded", i, N);
        chk("load_overlap", overlap, 0);
    endtask

    task automatic collect(input int nrows, input bit bp, input bit lat);
        for (int r = 0; r < nrows; r++) begin
            int cnt;
            int stall;
            logic [OW-1:0] hold_d;
            logic hold_l;
            cnt = 0;
            while (!m_valid && cnt < 3 * N) begin
                step();
                cnt++;
                if (bp) m_ready = 1'($urandom_range(0, 1));
            end
            chk("m_valid_seen", m_valid, 1);
            if (!m_valid) return;
            if (lat) chk("latency", cnt, N);
            chk("m_data", $signed(m_data), exp_y[r]);
            chk("m_last", m_last, (r == M - 1));
            chk("s_ready_in_emit", s_ready, 0);
            if (bp) begin
                hold_d  = m_data;
                hold_l  = m_last;
                stall   = 0;
                m_ready = 1'($urandom_range(0, 1));
                while (!m_ready && stall < 64) begin
                    step();
                    stall++;
                    chk("stall_valid", m_valid, 1);
                    chk("stall_data", $signed(m_data), $signed(hold_d));
                    chk("stall_last", m_last, hold_l);
                    m_ready = 1'($urandom_range(0, 1));
                end
            end
            m_ready = 1'b1;
            step();
            chk("m_valid_drop", m_valid, 0);
            chk("s_ready_after_row", s_ready, (r == M - 1));
        end
    endtask

    initial begin
        int seen;
        reset      = 1'b1;
        prbs       = '0;
        prbs_valid = 1'b0;
        s_data     = '0;
        s_valid    = 1'b0;
        m_ready    = 1'b0;
        repeat (3) step();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", $signed(m_data), 0);
        reset = 1'b0;

        // prbs not yet valid: offered samples must be ignored
        s_valid = 1'b1;
        s_data  = 12'h5A5;
        seen    = 0;
        repeat (100) begin
            step();
            if (s_ready || m_valid) seen++;
        end
        chk("wait_idle", seen, 0);
        s_valid = 1'b0;

        // all-ones chips, unit samples
        prbs = '1;
        for (int n = 0; n < N; n++) x_arr[n] = 1;
        build_model();
        prbs_valid = 1'b1;
        m_ready    = 1'b1;
        send_frame(1'b0);
        collect(M, 1'b0, 1'b1);

        // all-zero chips, most negative samples
        prbs = '0;
        for (int n = 0; n < N; n++) x_arr[n] = -2048;
        build_model();
        send_frame(1'b1);
        collect(M, 1'b0, 1'b1);

        // single chip set at index 0, ramp input
        prbs    = '0;
        prbs[0] = 1'b1;
        for (int n = 0; n < N; n++) x_arr[n] = n;
        build_model();
        send_frame(1'b0);
        collect(M, 1'b0, 1'b1);

        // random frames under backpressure
        repeat (2) begin
            randomize_prbs();
            randomize_x();
            build_model();
            send_frame(1'b1);
            collect(M, 1'b1, 1'b0);
        end

        // abort during row 5, then run a clean frame
        randomize_prbs();
        randomize_x();
        build_model();
        send_frame(1'b0);
        collect(5, 1'b0, 1'b0);
        repeat (10) step();
        prbs_valid = 1'b0;
        reset      = 1'b1;
        step();
        chk("mid_rst_s_ready", s_ready, 0);
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_m_last", m_last, 0);
        chk("mid_rst_m_data", $signed(m_data), 0);
        reset = 1'b0;
        seen  = 0;
        repeat (20) begin
            step();
            if (s_ready || m_valid) seen++;
        end
        chk("post_rst_wait", seen, 0);
        randomize_prbs();
        randomize_x();
        build_model();
        prbs_valid = 1'b1;
        send_frame(1'b1);
        collect(M, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
